// File: rtl/mips_mem_pkg.sv
// Shared memory-side definitions for the MIPS core: responder FSM states,
// default data-memory geometry/latency, and the load/store opcodes that the
// control unit decodes.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int unsigned DMEM_DEPTH_WORDS = 256;
  localparam int unsigned DMEM_LATENCY     = 2;
  localparam logic [31:0] DMEM_BASE_ADDR   = 32'h0000_0000;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

endpackage

// File: rtl/mips_dmem_responder_array.sv
// dmem_array: synchronous single-port word RAM with a registered read port.
// Read-first: a write and a read of the same word in one edge return the old value.
// Contents are not reset.
module dmem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write on we; read data always registered from the addressed word.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder: memory-side end of the core's lw/sw interface.
// One request at a time over valid/ready; the access happens on the edge that
// enters RESP, LATENCY cycles after acceptance. Response is held until consumed.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned byte addresses are reported as
// errors (no write, zero data) instead of targeting the containing word.
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int unsigned LATENCY     = DMEM_LATENCY,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam int unsigned CW       = $clog2(LATENCY + 1);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  dmem_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          load_q, load_d;
  logic          write_q;
  logic [31:0]   addr_q, wdata_q;

  logic          accept, enter_rsp;
  logic          acc_write, acc_err, mem_we;
  logic [31:0]   acc_addr, acc_wdata, mem_rdata;
  logic [32:0]   off;

  // With LATENCY==1 the access happens on the acceptance edge itself, before
  // the request is latched, so the access path takes the live request in IDLE.
  assign acc_write = (state_q == IDLE) ? req_write : write_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

  // 33-bit subtraction: a borrow sets bit 32, which alone exceeds SPAN, so a
  // single compare covers both "below base" and "past the end".
  assign off = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_err = (off >= SPAN) || (acc_addr[1:0] != 2'b00);
`else
  assign acc_err = (off >= SPAN);
`endif

  // Reset gates the write so a store aborted in WAIT never commits.
  assign mem_we = enter_rsp && acc_write && !acc_err && !reset;

  dmem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (off[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  // Next-state, counter and response-flag decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    load_d    = load_q;
    accept    = 1'b0;
    enter_rsp = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        accept = 1'b1;
        cnt_d  = CNT_LOAD;
        if (LATENCY == 1) begin
          state_d   = RESP;
          enter_rsp = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = RESP;
          enter_rsp = 1'b1;
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_rsp) begin
      err_d  = acc_err;
      load_d = !acc_write && !acc_err;
    end
  end

  // State, counter, latched request and response flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      load_q  <= load_d;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // The array keeps re-reading the latched word during RESP with no writes,
  // so its read data stays stable while the response is held.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && load_q) ? mem_rdata : 32'h0;

endmodule
